// File: rtl/fsrc_rx_pkg.sv
// fsrc_rx_pkg
//   Shared types for the fractional sample-rate receive hole generator.
//   fsrc_rx_state_t : controller state (IDLE = bypass, ARMED = waiting for
//                     first sample, RUN = phase-driven hole insertion).
package fsrc_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } fsrc_rx_state_t;

    // Any state other than IDLE means the phase accumulator is in control.
    function automatic logic state_is_busy(input fsrc_rx_state_t s);
        return (s != IDLE);
    endfunction

endpackage

// File: rtl/fsrc_rx_accum.sv
// fsrc_rx_accum
//   Phase accumulator with synchronous load and conditional add.
//   Ports:
//     clk, reset      : clock, synchronous active-high reset
//     load, set_val   : load phase with set_val (wins over add_en)
//     add_en, add_val : accumulate add_val modulo 2^ACCUM_WIDTH
//     accum           : current phase (registered)
//     carry           : carry of accum + add_val, valid every cycle
module fsrc_rx_accum #(
    parameter int ACCUM_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   add_en,
    input  logic [ACCUM_WIDTH-1:0] set_val,
    input  logic [ACCUM_WIDTH-1:0] add_val,
    output logic [ACCUM_WIDTH-1:0] accum,
    output logic                   carry
);

    logic [ACCUM_WIDTH-1:0] accum_q;
    logic [ACCUM_WIDTH-1:0] accum_d;
    logic [ACCUM_WIDTH:0]   sum;

    assign sum   = {1'b0, accum_q} + {1'b0, add_val};
    assign carry = sum[ACCUM_WIDTH];

    always_comb begin
        accum_d = accum_q;
        if (load) begin
            accum_d = set_val;
        end else if (add_en) begin
            accum_d = sum[ACCUM_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            accum_q <= '0;
        end else begin
            accum_q <= accum_d;
        end
    end

    assign accum = accum_q;

endmodule

// File: rtl/fsrc_rx_hole_gen.sv
// fsrc_rx_hole_gen
//   Drops ("holes") input samples whenever the phase accumulator carries,
//   thinning the sample stream by add_val / 2^ACCUM_WIDTH.
//
//   state | meaning
//   IDLE  | bypass: every sample passes, phase held
//   ARMED | phase loaded, waiting for the first sample
//   RUN   | each sample advances the phase; carry drops the sample
//
//   Ports:
//     clk, reset          : clock, synchronous active-high reset
//     start, stop         : load phase/arm, return to bypass (stop wins)
//     set_val, add_val    : initial phase, per-sample increment
//     in_valid, in_data   : input sample stream
//     out_valid, out_data : output stream, one-cycle latency
//     hole                : one-cycle flag for a dropped sample
//     accum               : current phase
//     hole_count          : saturating holes since last start
//     busy                : ARMED or RUN
module fsrc_rx_hole_gen
    import fsrc_rx_pkg::*;
#(
    parameter int ACCUM_WIDTH = 32,
    parameter int DATA_WIDTH  = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stop,
    input  logic [ACCUM_WIDTH-1:0] set_val,
    input  logic [ACCUM_WIDTH-1:0] add_val,
    input  logic                   in_valid,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic                   out_valid,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   hole,
    output logic [ACCUM_WIDTH-1:0] accum,
    output logic [CNT_WIDTH-1:0]   hole_count,
    output logic                   busy
);

    fsrc_rx_state_t         state_q;
    logic                   out_valid_q;
    logic [DATA_WIDTH-1:0]  out_data_q;
    logic                   hole_q;
    logic [CNT_WIDTH-1:0]   hole_count_q;
    logic                   busy_q;

    logic                   acc_load;
    logic                   acc_add;
    logic                   acc_carry;

    // A sample in the start/stop cycle is judged by the current state, so the
    // add is gated only by state; a start load overrides that add.
    assign acc_load = start & ~stop;
    assign acc_add  = in_valid & state_is_busy(state_q);

    fsrc_rx_accum #(
        .ACCUM_WIDTH(ACCUM_WIDTH)
    ) u_accum (
        .clk     (clk),
        .reset   (reset),
        .load    (acc_load),
        .add_en  (acc_add),
        .set_val (set_val),
        .add_val (add_val),
        .accum   (accum),
        .carry   (acc_carry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            hole_q       <= 1'b0;
            hole_count_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            hole_q      <= 1'b0;

            if (in_valid) begin
                if (state_q == IDLE) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= in_data;
                end else begin
                    // First sample in ARMED is already a RUN sample.
                    if (state_q == ARMED) begin
                        state_q <= RUN;
                    end
                    if (acc_carry) begin
                        hole_q <= 1'b1;
                        if (hole_count_q != '1) begin
                            hole_count_q <= hole_count_q + CNT_WIDTH'(1);
                        end
                    end else begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= in_data;
                    end
                end
            end

            // Control overrides the sample's state update; stop beats start.
            if (stop) begin
                if (state_q != IDLE) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            end else if (start) begin
                state_q      <= ARMED;
                busy_q       <= 1'b1;
                hole_count_q <= '0;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign hole       = hole_q;
    assign hole_count = hole_count_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_fsrc_rx_hole_gen.sv
module tb_fsrc_rx_hole_gen;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int CW = 2;

    logic          clk;
    logic          reset;
    logic          start;
    logic          stop;
    logic [AW-1:0] set_val;
    logic [AW-1:0] add_val;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          hole;
    logic [AW-1:0] accum;
    logic [CW-1:0] hole_count;
    logic          busy;

    int checks = 0;
    int errors = 0;

    fsrc_rx_hole_gen #(
        .ACCUM_WIDTH(AW),
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .set_val    (set_val),
        .add_val    (add_val),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .hole       (hole),
        .accum      (accum),
        .hole_count (hole_count),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start    = 1'b0;
        stop     = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin $display("FAIL reset_out_valid got %0b exp 0", out_valid); errors++; end
        checks++; if (hole !== 1'b0) begin $display("FAIL reset_hole got %0b exp 0", hole); errors++; end
        checks++; if (out_data !== 16'h0000) begin $display("FAIL reset_out_data got %h exp 0000", out_data); errors++; end
        checks++; if (accum !== 8'h00) begin $display("FAIL reset_accum got %h exp 00", accum); errors++; end
        checks++; if (hole_count !== 2'd0) begin $display("FAIL reset_hole_count got %0d exp 0", hole_count); errors++; end
        checks++; if (busy !== 1'b0) begin $display("FAIL reset_busy got %0b exp 0", busy); errors++; end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_bypass();
        idle_inputs();
        add_val  = 8'h80;
        in_valid = 1'b1;
        in_data  = 16'h1234;
        tick();
        checks++; if (out_valid !== 1'b1) begin $display("FAIL bypass_valid got %0b exp 1", out_valid); errors++; end
        checks++; if (out_data !== 16'h1234) begin $display("FAIL bypass_data got %h exp 1234", out_data); errors++; end
        checks++; if (hole !== 1'b0) begin $display("FAIL bypass_hole got %0b exp 0", hole); errors++; end
        checks++; if (accum !== 8'h00) begin $display("FAIL bypass_accum got %h exp 00", accum); errors++; end
        idle_inputs();
        stop = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin $display("FAIL bypass_gap_valid got %0b exp 0", out_valid); errors++; end
        checks++; if (out_data !== 16'h1234) begin $display("FAIL bypass_hold_data got %h exp 1234", out_data); errors++; end
        checks++; if (busy !== 1'b0) begin $display("FAIL stop_in_idle_busy got %0b exp 0", busy); errors++; end
        stop = 1'b0;
    endtask

    task automatic test_start_sample();
        idle_inputs();
        set_val  = 8'h10;
        add_val  = 8'h40;
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h00AB;
        tick();
        checks++; if (out_valid !== 1'b1) begin $display("FAIL start_cycle_valid got %0b exp 1", out_valid); errors++; end
        checks++; if (out_data !== 16'h00AB) begin $display("FAIL start_cycle_data got %h exp 00ab", out_data); errors++; end
        checks++; if (busy !== 1'b1) begin $display("FAIL start_cycle_busy got %0b exp 1", busy); errors++; end
        checks++; if (accum !== 8'h10) begin $display("FAIL start_cycle_accum got %h exp 10", accum); errors++; end
        idle_inputs();
    endtask

    task automatic test_holes();
        logic [AW-1:0] exp_acc;
        logic          exp_hole;
        idle_inputs();
        set_val = 8'h00;
        add_val = 8'h40;
        start   = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (accum !== 8'h00) begin $display("FAIL holes_load_accum got %h exp 00", accum); errors++; end
        checks++; if (hole_count !== 2'd0) begin $display("FAIL holes_load_count got %0d exp 0", hole_count); errors++; end
        for (int i = 1; i <= 12; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(i);
            exp_acc  = 8'((i * 64) % 256);
            exp_hole = ((i % 4) == 0);
            tick();
            checks++; if (hole !== exp_hole) begin $display("FAIL holes_flag s%0d got %0b exp %0b", i, hole, exp_hole); errors++; end
            checks++; if (out_valid !== !exp_hole) begin $display("FAIL holes_valid s%0d got %0b exp %0b", i, out_valid, !exp_hole); errors++; end
            if (!exp_hole) begin
                checks++; if (out_data !== 16'(i)) begin $display("FAIL holes_data s%0d got %0d exp %0d", i, out_data, i); errors++; end
            end
            checks++; if (accum !== exp_acc) begin $display("FAIL holes_accum s%0d got %h exp %h", i, accum, exp_acc); errors++; end
        end
        idle_inputs();
        tick();
        checks++; if (hole_count !== 2'd3) begin $display("FAIL holes_count got %0d exp 3", hole_count); errors++; end
        checks++; if (out_valid !== 1'b0 || hole !== 1'b0) begin $display("FAIL holes_idle_cycle got v%0b h%0b exp v0 h0", out_valid, hole); errors++; end
    endtask

    task automatic test_start_stop();
        idle_inputs();
        in_valid = 1'b1;
        in_data  = 16'd13;
        tick();
        checks++; if (accum !== 8'h40) begin $display("FAIL ss_pre_accum got %h exp 40", accum); errors++; end
        idle_inputs();
        set_val = 8'h55;
        start   = 1'b1;
        stop    = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin $display("FAIL ss_busy got %0b exp 0", busy); errors++; end
        checks++; if (accum !== 8'h40) begin $display("FAIL ss_accum got %h exp 40", accum); errors++; end
        checks++; if (hole_count !== 2'd3) begin $display("FAIL ss_count got %0d exp 3", hole_count); errors++; end
        idle_inputs();
        in_valid = 1'b1;
        in_data  = 16'h0021;
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 16'h0021) begin $display("FAIL ss_bypass got v%0b d%h exp v1 d0021", out_valid, out_data); errors++; end
        checks++; if (accum !== 8'h40) begin $display("FAIL ss_bypass_accum got %h exp 40", accum); errors++; end
        idle_inputs();
    endtask

    task automatic test_first_hole();
        idle_inputs();
        set_val = 8'hC0;
        add_val = 8'h40;
        start   = 1'b1;
        tick();
        idle_inputs();
        in_valid = 1'b1;
        in_data  = 16'h0001;
        tick();
        checks++; if (hole !== 1'b1 || out_valid !== 1'b0) begin $display("FAIL first_hole got h%0b v%0b exp h1 v0", hole, out_valid); errors++; end
        checks++; if (accum !== 8'h00) begin $display("FAIL first_hole_accum got %h exp 00", accum); errors++; end
        checks++; if (hole_count !== 2'd1) begin $display("FAIL first_hole_count got %0d exp 1", hole_count); errors++; end
        idle_inputs();
    endtask

    task automatic test_gapped();
        logic       vld [8];
        logic [7:0] e_acc [8];
        logic       e_hole [8];
        logic       e_ov [8];
        vld    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        e_acc  = '{8'h80, 8'h80, 8'h80, 8'h00, 8'h80, 8'h80, 8'h80, 8'h00};
        e_hole = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        e_ov   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        idle_inputs();
        set_val = 8'h00;
        add_val = 8'h80;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = vld[i];
            in_data  = 16'(16'h0100 + i);
            tick();
            checks++; if (accum !== e_acc[i]) begin $display("FAIL gap_accum c%0d got %h exp %h", i, accum, e_acc[i]); errors++; end
            checks++; if (hole !== e_hole[i]) begin $display("FAIL gap_hole c%0d got %0b exp %0b", i, hole, e_hole[i]); errors++; end
            checks++; if (out_valid !== e_ov[i]) begin $display("FAIL gap_valid c%0d got %0b exp %0b", i, out_valid, e_ov[i]); errors++; end
        end
        idle_inputs();
    endtask

    task automatic test_saturate();
        logic [1:0] e_cnt [5];
        e_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        idle_inputs();
        set_val = 8'hFF;
        add_val = 8'hFF;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(i);
            tick();
            checks++; if (hole !== 1'b1 || out_valid !== 1'b0) begin $display("FAIL sat_hole n%0d got h%0b v%0b exp h1 v0", i, hole, out_valid); errors++; end
            checks++; if (hole_count !== e_cnt[i]) begin $display("FAIL sat_count n%0d got %0d exp %0d", i, hole_count, e_cnt[i]); errors++; end
            checks++; if (accum !== 8'(8'hFE - i)) begin $display("FAIL sat_accum n%0d got %h exp %h", i, accum, 8'(8'hFE - i)); errors++; end
        end
        in_valid = 1'b1;
        stop     = 1'b1;
        tick();
        checks++; if (hole !== 1'b1 || busy !== 1'b0) begin $display("FAIL stop_sample got h%0b b%0b exp h1 b0", hole, busy); errors++; end
        checks++; if (accum !== 8'hF9) begin $display("FAIL stop_sample_accum got %h exp f9", accum); errors++; end
        idle_inputs();
        set_val = 8'h00;
        start   = 1'b1;
        tick();
        checks++; if (hole_count !== 2'd0) begin $display("FAIL sat_clear got %0d exp 0", hole_count); errors++; end
        checks++; if (busy !== 1'b1) begin $display("FAIL sat_rearm_busy got %0b exp 1", busy); errors++; end
        idle_inputs();
    endtask

    task automatic test_zero_add();
        idle_inputs();
        set_val = 8'h37;
        add_val = 8'h00;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(16'h0A00 + i);
            tick();
            checks++; if (out_valid !== 1'b1 || hole !== 1'b0) begin $display("FAIL zero_add n%0d got v%0b h%0b exp v1 h0", i, out_valid, hole); errors++; end
            checks++; if (accum !== 8'h37) begin $display("FAIL zero_add_accum n%0d got %h exp 37", i, accum); errors++; end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_run();
        idle_inputs();
        set_val = 8'h00;
        add_val = 8'h40;
        start   = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'h0001;
        tick();
        checks++; if (accum !== 8'h40 || busy !== 1'b1) begin $display("FAIL rst_run_pre got a%h b%0b exp a40 b1", accum, busy); errors++; end
        reset    = 1'b1;
        start    = 1'b1;
        in_data  = 16'h0077;
        tick();
        checks++; if (out_valid !== 1'b0 || hole !== 1'b0) begin $display("FAIL rst_run_out got v%0b h%0b exp v0 h0", out_valid, hole); errors++; end
        checks++; if (out_data !== 16'h0000) begin $display("FAIL rst_run_data got %h exp 0000", out_data); errors++; end
        checks++; if (accum !== 8'h00 || hole_count !== 2'd0) begin $display("FAIL rst_run_state got a%h c%0d exp a00 c0", accum, hole_count); errors++; end
        checks++; if (busy !== 1'b0) begin $display("FAIL rst_run_busy got %0b exp 0", busy); errors++; end
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'h0099;
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 16'h0099) begin $display("FAIL rst_run_bypass got v%0b d%h exp v1 d0099", out_valid, out_data); errors++; end
        checks++; if (accum !== 8'h00) begin $display("FAIL rst_run_bypass_accum got %h exp 00", accum); errors++; end
        idle_inputs();
    endtask

    initial begin
        reset   = 1'b1;
        set_val = '0;
        add_val = '0;
        idle_inputs();
        test_reset();
        test_bypass();
        test_start_sample();
        test_holes();
        test_start_stop();
        test_first_hole();
        test_gapped();
        test_saturate();
        test_zero_add();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsrc_rx_hole_gen.md
FSRC_RX_HOLE_GEN -- requirements
Module: fsrc_rx_hole_gen

Interface
REQ-001 SHALL have parameter ACCUM_WIDTH, default 32, phase accumulator width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, sample width.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, hole counter width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse that loads the phase and arms the block.
REQ-007 SHALL have port stop  input  1  one-cycle pulse that returns the block to bypass.
REQ-008 SHALL have port set_val  input  ACCUM_WIDTH  initial phase loaded on start.
REQ-009 SHALL have port add_val  input  ACCUM_WIDTH  phase increment per accepted sample.
REQ-010 SHALL have port in_valid  input  1  input sample strobe.
REQ-011 SHALL have port in_data  input  DATA_WIDTH  input sample.
REQ-012 SHALL have port out_valid  output  1  output sample strobe, low on holes.
REQ-013 SHALL have port out_data  output  DATA_WIDTH  registered sample.
REQ-014 SHALL have port hole  output  1  one-cycle flag marking a dropped sample.
REQ-015 SHALL have port accum  output  ACCUM_WIDTH  current phase.
REQ-016 SHALL have port hole_count  output  CNT_WIDTH  saturating count of holes since the last start.
REQ-017 SHALL have port busy  output  1  high in ARMED or RUN.

Function
REQ-018 SHALL implement the states IDLE, ARMED and RUN.
REQ-019 In IDLE, each in_valid SHALL pass to out_valid/out_data after exactly 1 cycle, with hole=0 and accum held.
REQ-020 start in any state SHALL load accum<=set_val, clear hole_count, and enter ARMED on the next cycle.
REQ-021 stop in ARMED or RUN SHALL enter IDLE; stop in IDLE SHALL have no effect.
REQ-022 start and stop in the same cycle: stop SHALL win, and accum and hole_count SHALL be unchanged.
REQ-023 ARMED: the first in_valid SHALL move the state to RUN and SHALL be processed as a RUN sample in that same cycle.
REQ-024 RUN sample processing: sum = accum + add_val at ACCUM_WIDTH+1 bits; accum <= sum[ACCUM_WIDTH-1:0]; carry = sum[ACCUM_WIDTH].
REQ-025 carry=1 SHALL drop that sample: next cycle out_valid=0, hole=1, hole_count+1 (saturate at all-ones).
REQ-026 carry=0 SHALL pass that sample: next cycle out_valid=1, out_data=in_data, hole=0.
REQ-027 in_valid=0 in any state SHALL leave accum unchanged and give out_valid=0 and hole=0 on the next cycle.
REQ-028 Phase wrap SHALL be modulo 2^ACCUM_WIDTH; add_val=0 SHALL never produce a hole.
REQ-029 out_data SHALL update only on in_valid and SHALL hold otherwise.
REQ-030 A sample arriving in the stop cycle SHALL be processed under the pre-stop state.
REQ-031 A sample arriving in the start cycle SHALL be processed under the pre-start state.

Reset
REQ-032 reset SHALL override start and stop.
REQ-033 On reset, state SHALL be IDLE, and accum, hole_count, out_valid, hole, out_data and busy SHALL all be 0.
REQ-034 Reset mid-RUN SHALL discard the pending sample, so out_valid=0 in the cycle after reset.

Structure
REQ-035 Shared package fsrc_rx_pkg SHALL hold the state enum fsrc_rx_state_t (IDLE, ARMED, RUN).
REQ-036 The phase accumulator SHALL be a separate sub-module fsrc_rx_accum (set, add, carry out).
REQ-037 All outputs SHALL be registered, and there SHALL be no combinational path from input to output.

Verification
REQ-038 ACCUM_WIDTH=8, set_val=0x00, add_val=0x40, start, then 12 consecutive samples 1..12 -> holes on samples 4, 8 and 12; out_data 1,2,3,5,6,7,9,10,11; hole_count=3.
REQ-039 set_val=0xC0, add_val=0x40 -> first sample is a hole and accum=0x00 after it.
REQ-040 Gapped in_valid (1,0,0,1) with add_val=0x80 -> accum advances only on valid cycles, and a hole occurs on every 2nd valid sample.
REQ-041 start and stop together while in RUN -> state stays IDLE path (stop wins), and hole_count and accum are unchanged.
REQ-042 CNT_WIDTH=2 with 5 holes -> hole_count saturates at 3; a subsequent start clears it to 0.
REQ-043 reset asserted mid-RUN with in_valid=1 -> next cycle all outputs are 0 and state is IDLE; the next sample passes in bypass.
